// File: rtl/spi_frame_pkg.sv
// Frame layout constants, controller states and request record shared by
// the SPI controller and the peripheral side.
package spi_frame_pkg;

    localparam int ADDR_BITS      = 10;
    localparam int DATA_BITS      = 8;
    localparam int DEAD1_BITS_DEF = 8;
    localparam int DEAD2_BITS_DEF = 6;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef struct packed {
        logic                 rw;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } spi_req_t;

    // Total bit slots of one frame: rw, address, dead1, data, dead2.
    function automatic int frame_bits(input int dead1, input int dead2);
        return 1 + ADDR_BITS + dead1 + DATA_BITS + dead2;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host request/response and SPI pin bundle of the SPI controller.
interface spi_master_ctrl_if;
    import spi_frame_pkg::*;

    logic                 start;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] rdata;
    logic                 SCLK;
    logic                 CSN;
    logic                 MOSI;
    logic                 MISO;

    modport master (
        input  start, rw, addr, wdata, MISO,
        output busy, done, rdata, SCLK, CSN, MOSI
    );

    modport slave (
        output start, rw, addr, wdata, MISO,
        input  busy, done, rdata, SCLK, CSN, MOSI
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period down-counter, registered SCLK (mode 0, idle
// low). rise_o/fall_o flag the clk edge at which SCLK is about to change, so
// the controller can update MOSI on that very edge.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic       sclk_q;
    logic       tc;

    assign tc     = (cnt_q == 8'd0);
    assign rise_o = run_i && tc && !sclk_q;
    assign fall_o = run_i && tc && sclk_q;
    assign sclk_o = sclk_q;

    // Count down each half period; stopping the generator parks SCLK low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= HALF_LOAD;
            sclk_q <= 1'b0;
        end else if (!run_i) begin
            cnt_q  <= HALF_LOAD;
            sclk_q <= 1'b0;
        end else if (tc) begin
            cnt_q  <= HALF_LOAD;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q - 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator for the 33-bit register-access frame: rw, addr, dead1,
// data, dead2. Captures 8 MISO bits from the data slots on reads.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | CSN high, SCLK low, waiting for start
//   ST_SHIFT | CSN low, shifting slots; tail_q marks the half period after
//            | the last falling edge before CSN is released
//   ST_GAP   | CSN high, done pulsed on entry, busy held for 2*CLK_DIV
module spi_master_ctrl
    import spi_frame_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int DEAD1_BITS = DEAD1_BITS_DEF,
    parameter int DEAD2_BITS = DEAD2_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_ctrl_if.master bus
);

    localparam int         FB         = frame_bits(DEAD1_BITS, DEAD2_BITS);
    localparam int         DATA_LO    = 1 + ADDR_BITS + DEAD1_BITS;
    localparam logic [5:0] LAST_SLOT  = 6'(FB - 1);
    localparam logic [5:0] DATA_FIRST = 6'(DATA_LO);
    localparam logic [5:0] DATA_LAST  = 6'(DATA_LO + DATA_BITS - 1);
    localparam logic [8:0] TAIL_LOAD  = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LOAD   = 9'(2 * CLK_DIV - 1);

    logic [1:0]           state_q, state_d;
    logic [FB-1:0]        tx_q, tx_d;
    logic [5:0]           slot_q, slot_d;
    logic                 tail_q, tail_d;
    logic [8:0]           tmr_q, tmr_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 rw_q, rw_d;
    logic                 csn_q, csn_d;
    logic                 mosi_q, mosi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    spi_req_t      req;
    logic [FB-1:0] frame_w;
    logic          sclk_run, sclk, sclk_rise, sclk_fall;
    logic          in_data;

    assign req.rw   = bus.rw;
    assign req.addr = bus.addr;
    assign req.data = (bus.rw == RW_WRITE) ? bus.wdata : '0;
    assign frame_w  = {req.rw, req.addr, {DEAD1_BITS{1'b0}}, req.data, {DEAD2_BITS{1'b0}}};

    assign sclk_run = (state_q == ST_SHIFT) && !tail_q;
    assign in_data  = (slot_q >= DATA_FIRST) && (slot_q <= DATA_LAST);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (sclk_run),
        .sclk_o (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Frame sequencing: accept, slot shifting, tail delay, gap timer.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        slot_d  = slot_q;
        tail_d  = tail_q;
        tmr_d   = tmr_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        csn_d   = csn_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    mosi_d  = frame_w[FB-1];
                    tx_d    = frame_w << 1;
                    rw_d    = bus.rw;
                    slot_d  = 6'd0;
                    tail_d  = 1'b0;
                    rx_d    = '0;
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tail_q) begin
                    if (tmr_q == 9'd0) begin
                        state_d = ST_GAP;
                        tail_d  = 1'b0;
                        tmr_d   = GAP_LOAD;
                        csn_d   = 1'b1;
                        mosi_d  = 1'b0;
                        done_d  = 1'b1;
                        if (rw_q == RW_READ) begin
                            rdata_d = rx_q;
                        end
                    end else begin
                        tmr_d = tmr_q - 9'd1;
                    end
                end else begin
                    if (sclk_rise && in_data) begin
                        rx_d = {rx_q[DATA_BITS-2:0], bus.MISO};
                    end
                    if (sclk_fall) begin
                        mosi_d = tx_q[FB-1];
                        tx_d   = tx_q << 1;
                        if (slot_q == LAST_SLOT) begin
                            tail_d = 1'b1;
                            tmr_d  = TAIL_LOAD;
                        end else begin
                            slot_d = slot_q + 6'd1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tmr_q == 9'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    tmr_d = tmr_q - 9'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tail_d  = 1'b0;
                csn_d   = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            slot_q  <= 6'd0;
            tail_q  <= 1'b0;
            tmr_q   <= 9'd0;
            rx_q    <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            slot_q  <= slot_d;
            tail_q  <= tail_d;
            tmr_q   <= tmr_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            csn_q   <= csn_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.SCLK  = sclk;
    assign bus.CSN   = csn_q;
    assign bus.MOSI  = mosi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: CLK_DIV=2 instance driven from a vector table,
// CLK_DIV=1 instance for back-to-back frames, plus a mid-frame reset.
module tb_spi_master_ctrl;
    import spi_frame_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_ctrl_if if0 ();
    spi_master_ctrl_if if1 ();

    spi_master_ctrl #(.CLK_DIV(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    spi_master_ctrl #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Peripheral model for instance 0: MISO mode 0 = pattern on data slots
    // (1 elsewhere), 1 = stuck high, 2 = stuck low.
    int         miso_mode = 2;
    logic [7:0] miso_pat  = 8'h00;

    function automatic logic miso_bit(input int slot);
        if (miso_mode == 1) return 1'b1;
        if (miso_mode == 2) return 1'b0;
        if (slot >= 19 && slot <= 26) return miso_pat[26 - slot];
        return 1'b1;
    endfunction

    logic [32:0] cap0 = '0;
    int          nrise0 = 0, nfall0 = 0, ndone0 = 0, csnlow0 = 0;
    logic        prev_csn0 = 1'b1, prev_sclk0 = 1'b0;

    always @(negedge clk) begin
        if (prev_csn0 && !if0.CSN) begin
            nrise0 = 0;
            nfall0 = 0;
        end
        if (!prev_sclk0 && if0.SCLK) begin
            cap0 = {cap0[31:0], if0.MOSI};
            nrise0++;
        end
        if (prev_sclk0 && !if0.SCLK) nfall0++;
        if (!if0.CSN) csnlow0++;
        if (if0.done) ndone0++;
        prev_csn0  = if0.CSN;
        prev_sclk0 = if0.SCLK;
        if0.MISO   = miso_bit(nfall0);
    end

    // Monitor for instance 1: frames, CSN-fall and done cycle stamps.
    logic [32:0] cap1 = '0;
    logic [32:0] frames1 [4];
    int          rises1 [4];
    int          donec1 [4];
    int          csnf1 [4];
    int          nrise1 = 0, nd1 = 0, ncf1 = 0, cyc1 = 0;
    logic        prev_csn1 = 1'b1, prev_sclk1 = 1'b0;

    always @(negedge clk) begin
        cyc1++;
        if (prev_csn1 && !if1.CSN) begin
            nrise1 = 0;
            if (ncf1 < 4) csnf1[ncf1] = cyc1;
            ncf1++;
        end
        if (!prev_sclk1 && if1.SCLK) begin
            cap1 = {cap1[31:0], if1.MOSI};
            nrise1++;
        end
        if (if1.done) begin
            if (nd1 < 4) begin
                frames1[nd1] = cap1;
                rises1[nd1]  = nrise1;
                donec1[nd1]  = cyc1;
            end
            nd1++;
        end
        prev_csn1  = if1.CSN;
        prev_sclk1 = if1.SCLK;
    end

    typedef struct {
        logic        rw;
        logic [9:0]  addr;
        logic [7:0]  wdata;
        int          mode;
        logic [7:0]  pat;
        bit          repulse;
        logic [32:0] exp_frame;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [6];

    // One frame on instance 0 with all per-frame checks (CLK_DIV = 2).
    task automatic run0(input int idx, input vec_t v);
        int  c0, d0, n;
        bit  got;
        @(posedge clk);
        c0 = csnlow0;
        d0 = ndone0;
        miso_mode = v.mode;
        miso_pat  = v.pat;
        @(negedge clk);
        if0.start = 1'b1;
        if0.rw    = v.rw;
        if0.addr  = v.addr;
        if0.wdata = v.wdata;
        @(negedge clk);
        if0.start = 1'b0;
        if0.rw    = ~v.rw;
        if0.addr  = ~v.addr;
        if0.wdata = ~v.wdata;
        chk($sformatf("v%0d_t1_csn", idx), 64'(if0.CSN), 64'd0);
        chk($sformatf("v%0d_t1_busy", idx), 64'(if0.busy), 64'd1);
        chk($sformatf("v%0d_t1_sclk", idx), 64'(if0.SCLK), 64'd0);
        chk($sformatf("v%0d_t1_mosi", idx), 64'(if0.MOSI), 64'(v.rw));
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (v.repulse && i == 20) begin
                if0.start = 1'b1;
                if0.rw    = RW_READ;
                if0.addr  = 10'h3FF;
                if0.wdata = 8'h00;
            end
            if (v.repulse && i == 21) if0.start = 1'b0;
            if (if0.done) begin
                got = 1'b1;
                break;
            end
        end
        if0.start = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), 64'(got), 64'd1);
        chk($sformatf("v%0d_rdata", idx), 64'(if0.rdata), 64'(v.exp_rdata));
        n = 0;
        while (if0.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_busy_tail", idx), 64'(n), 64'd4);
        repeat (3) @(posedge clk);
        chk($sformatf("v%0d_frame", idx), 64'(cap0), 64'(v.exp_frame));
        chk($sformatf("v%0d_rises", idx), 64'(nrise0), 64'd33);
        chk($sformatf("v%0d_csn_low", idx), 64'(csnlow0 - c0), 64'd134);
        chk($sformatf("v%0d_dones", idx), 64'(ndone0 - d0), 64'd1);
    endtask

    initial begin
        int  d0;
        bit  got;
        vecs[0] = '{1'b1, 10'h002, 8'hA5, 2, 8'h00, 1'b0, {1'b1, 10'h002, 8'h00, 8'hA5, 6'h00}, 8'h00};
        vecs[1] = '{1'b0, 10'h080, 8'h77, 0, 8'h3C, 1'b0, {1'b0, 10'h080, 8'h00, 8'h00, 6'h00}, 8'h3C};
        vecs[2] = '{1'b1, 10'h002, 8'hA5, 1, 8'h00, 1'b1, {1'b1, 10'h002, 8'h00, 8'hA5, 6'h00}, 8'h3C};
        vecs[3] = '{1'b0, 10'h3FF, 8'h00, 2, 8'h00, 1'b0, {1'b0, 10'h3FF, 8'h00, 8'h00, 6'h00}, 8'h00};
        vecs[4] = '{1'b0, 10'h3FF, 8'h00, 1, 8'h00, 1'b0, {1'b0, 10'h3FF, 8'h00, 8'h00, 6'h00}, 8'hFF};
        vecs[5] = '{1'b1, 10'h155, 8'hC3, 2, 8'h00, 1'b0, {1'b1, 10'h155, 8'h00, 8'hC3, 6'h00}, 8'h00};

        if0.start = 1'b0; if0.rw = 1'b0; if0.addr = '0; if0.wdata = '0;
        if1.start = 1'b0; if1.rw = 1'b0; if1.addr = '0; if1.wdata = '0; if1.MISO = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_csn", 64'(if0.CSN), 64'd1);
        chk("rst_sclk", 64'(if0.SCLK), 64'd0);
        chk("rst_mosi", 64'(if0.MOSI), 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);
        chk("rst_done", 64'(if0.done), 64'd0);
        chk("rst_rdata", 64'(if0.rdata), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) run0(v, vecs[v]);

        // Reset in slot 15 of a write frame.
        @(posedge clk);
        d0 = ndone0;
        @(negedge clk);
        if0.start = 1'b1; if0.rw = RW_WRITE; if0.addr = 10'h155; if0.wdata = 8'hC3;
        @(negedge clk);
        if0.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (nfall0 >= 15) begin
                got = 1'b1;
                break;
            end
        end
        chk("arst_slot15_seen", 64'(got), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_csn", 64'(if0.CSN), 64'd1);
        chk("arst_sclk", 64'(if0.SCLK), 64'd0);
        chk("arst_mosi", 64'(if0.MOSI), 64'd0);
        chk("arst_busy", 64'(if0.busy), 64'd0);
        chk("arst_rdata", 64'(if0.rdata), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        chk("arst_no_done", 64'(ndone0 - d0), 64'd0);
        chk("arst_idle_csn", 64'(if0.CSN), 64'd1);
        run0(5, vecs[5]);

        // CLK_DIV=1: start held high across two frames.
        @(negedge clk);
        if1.start = 1'b1; if1.rw = RW_WRITE; if1.addr = 10'h155; if1.wdata = 8'hC3;
        repeat (5) @(negedge clk);
        if1.addr = 10'h2AA; if1.wdata = 8'h3C;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (ncf1 >= 2) begin
                got = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if1.start = 1'b0;
        chk("b2b_second_accept", 64'(got), 64'd1);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (nd1 >= 2) break;
        end
        repeat (6) @(posedge clk);
        chk("b2b_dones", 64'(nd1), 64'd2);
        chk("b2b_frame1", 64'(frames1[0]), 64'({1'b1, 10'h155, 8'h00, 8'hC3, 6'h00}));
        chk("b2b_frame2", 64'(frames1[1]), 64'({1'b1, 10'h2AA, 8'h00, 8'h3C, 6'h00}));
        chk("b2b_rises1", 64'(rises1[0]), 64'd33);
        chk("b2b_rises2", 64'(rises1[1]), 64'd33);
        chk("b2b_csn_low1", 64'(donec1[0] - csnf1[0]), 64'd67);
        chk("b2b_restart_gap", 64'(csnf1[1] - donec1[0]), 64'd3);
        chk("b2b_busy_end", 64'(if1.busy), 64'd0);
        chk("b2b_rdata", 64'(if1.rdata), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI controller (initiator) that generates the 33-bit register-access frames decoded by the design's SPI peripheral interface. Takes a host request (read/write, 10-bit address, 8-bit write data), produces SCLK/CSN/MOSI from the system clock, and captures the 8-bit read data returned on MISO. It is used as the on-board or bench-side driver for the QAM modulator register map and its FIFOs.

## Interface

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 1..255.
- DEAD1_BITS, 8: dead-time bit slots between the address and data fields.
- DEAD2_BITS, 6: trailing dead-time bit slots after the data field.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; accepted only in IDLE.
- rw  in  1  1 = write, 0 = read; captured on accept.
- addr  in  10  register address; captured on accept.
- wdata  in  8  write data; captured on accept; ignored for reads.
- busy  out  1  high from the cycle after accept until return to IDLE.
- done  out  1  one-cycle pulse at frame end.
- rdata  out  8  last read result; updated only on read done.
- SCLK  out  1  serial clock; idle low (mode 0).
- CSN  out  1  chip select, active low.
- MOSI  out  1  serial data to peripheral.
- MISO  in  1  serial data from peripheral.

## Operation

- Frame order (FRAME_BITS = 1+10+DEAD1_BITS+8+DEAD2_BITS = 33 by default): rw; addr[9:0] MSB first; DEAD1 zeros; data[7:0] MSB first (wdata for writes, zeros for reads); DEAD2 zeros.
- Peripheral samples MOSI on SCLK rising edge and drives MISO on falling edge. Controller changes MOSI only on SCLK falling edges (first bit at CSN assertion); samples MISO on the rising edges of the 8 data-field slots, MSB first.
- States: IDLE -> SHIFT (on start) -> GAP (after last falling edge + CLK_DIV) -> IDLE (after 2*CLK_DIV cycles).
- IDLE: CSN=1, SCLK=0, MOSI=0, busy=0. start=1 latches rw/addr/wdata.
- SHIFT: CSN=0; SCLK toggles every CLK_DIV clk cycles; 6-bit slot counter counts 0..FRAME_BITS-1.
- GAP: CSN=1; done pulses on GAP entry; busy stays high.
- start while busy: ignored, no queueing. Input changes after accept: ignored.
- Read: shift register of sampled MISO bits copied to rdata at done. Write: rdata unchanged.
- Reset (any time, including mid-frame): immediately CSN=1, SCLK=0, MOSI=0, busy=0, done=0, rdata=0, state IDLE; no done for the aborted frame.

## Timing

- All outputs registered; no combinational path from inputs to SCLK/CSN/MOSI.
- Accept at cycle T0. T1: CSN=0, busy=1, MOSI=rw, SCLK=0.
- Rising edge of slot k at T1+(2k+1)*CLK_DIV; falling edge at T1+(2k+2)*CLK_DIV.
- CSN rises and done pulses at T1+2*CLK_DIV*FRAME_BITS+CLK_DIV (CSN low 67*CLK_DIV cycles by default).
- busy falls 2*CLK_DIV cycles after done; earliest next accept is the cycle busy is low.
- rdata valid the same cycle as done.

## Structure

- Shared package spi_frame_pkg: ADDR_BITS=10, DATA_BITS=8, RW_WRITE=1, RW_READ=0, default dead-time counts, FRAME_BITS function, state enumeration. The peripheral side uses the same constants.
- One sub-module: spi_sclk_gen (CLK_DIV half-period counter, run/clear input, registered SCLK plus single-cycle rise/fall strobes). The FSM, slot counter and shift registers live in the top.

## Test plan

- Write, CLK_DIV=2, addr=0x002, wdata=0xA5: MOSI at 33 rising edges = 1, 0000000010, 8x0, 10100101, 6x0; CSN low 134 cycles; done once; rdata stays 0x00.
- Read, addr=0x080, MISO model returns 0x3C on the data slots: MOSI data field all 0; rdata=0x3C at done.
- start re-pulsed mid-frame with addr=0x3FF: frame and captured fields unchanged; only one done.
- rst_n low at slot 15: CSN=1, SCLK=0, MOSI=0, busy=0 asynchronously; no done; next request runs a complete frame.
- CLK_DIV=1, two back-to-back writes (start held high): second CSN falling edge exactly 2 cycles after first done plus one accept cycle; both frames bit-exact.
- Boundary addr=0x3FF read with MISO stuck 1: rdata=0xFF; MISO stuck 0: rdata=0x00.
